// File: rtl/mipi_csi_rx_header_ecc_pipe_if.sv
// Header stream bundle for the CSI-2 header ECC pipe.
// Valid/ready: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and payload stable until that transfer.
// hdr_* is the upstream side (DUT sinks); out_* is the downstream side (DUT sources).
interface mipi_csi_rx_header_ecc_pipe_if;
    logic        hdr_valid_i;
    logic        hdr_ready_o;
    logic [31:0] packet_header_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] packet_length_o;
    logic [1:0]  vc_id_o;
    logic [5:0]  data_type_o;
    logic [5:0]  syndrome_o;
    logic        no_error_o;
    logic        corrected_error_o;
    logic        error_o;

    // Environment side: drives headers in, accepts decoded results.
    modport master (
        output hdr_valid_i, packet_header_i, out_ready_i,
        input  hdr_ready_o, out_valid_o, packet_length_o, vc_id_o, data_type_o,
               syndrome_o, no_error_o, corrected_error_o, error_o
    );

    // Decoder side.
    modport slave (
        input  hdr_valid_i, packet_header_i, out_ready_i,
        output hdr_ready_o, out_valid_o, packet_length_o, vc_id_o, data_type_o,
               syndrome_o, no_error_o, corrected_error_o, error_o
    );
endinterface

// File: rtl/mipi_csi_rx_header_ecc_pipe.sv
// Pipelined CSI-2 packet-header ECC checker/corrector.
// Computes the 6-bit Hamming syndrome, corrects single-bit errors, optionally
// drops uncorrectable headers, filters by (corrected) virtual channel and keeps
// saturating statistics. PIPE_STAGES=2 registers the syndrome before
// correction; PIPE_STAGES=1 does both in front of the output register.
module mipi_csi_rx_header_ecc_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter bit DROP_UNCORR = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    mipi_csi_rx_header_ecc_pipe_if.slave bus,
    input  logic [3:0]                   vc_mask_i,
    input  logic                         cnt_clr_i,
    output logic [CNT_W-1:0]             cnt_corrected_o,
    output logic [CNT_W-1:0]             cnt_uncorrected_o,
    output logic [CNT_W-1:0]             cnt_dropped_o
);

    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
        $error("mipi_csi_rx_header_ecc_pipe: PIPE_STAGES must be 1 or 2");
    end

    // CSI-2 header parity over the 24-bit data vector D.
    function automatic logic [5:0] ecc_parity(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
               d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
               d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
               d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
               d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

    // Map a syndrome onto the data bit it identifies; zero if it names no column.
    function automatic logic [23:0] column_flip(input logic [5:0] syn);
        logic [23:0] m;
        m = '0;
        case (syn)
            6'h07: m[0]  = 1'b1;
            6'h0B: m[1]  = 1'b1;
            6'h0D: m[2]  = 1'b1;
            6'h0E: m[3]  = 1'b1;
            6'h13: m[4]  = 1'b1;
            6'h15: m[5]  = 1'b1;
            6'h16: m[6]  = 1'b1;
            6'h19: m[7]  = 1'b1;
            6'h1A: m[8]  = 1'b1;
            6'h1C: m[9]  = 1'b1;
            6'h23: m[10] = 1'b1;
            6'h25: m[11] = 1'b1;
            6'h26: m[12] = 1'b1;
            6'h29: m[13] = 1'b1;
            6'h2A: m[14] = 1'b1;
            6'h2C: m[15] = 1'b1;
            6'h31: m[16] = 1'b1;
            6'h32: m[17] = 1'b1;
            6'h34: m[18] = 1'b1;
            6'h38: m[19] = 1'b1;
            6'h1F: m[20] = 1'b1;
            6'h2F: m[21] = 1'b1;
            6'h37: m[22] = 1'b1;
            6'h3B: m[23] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Input side: D = {WC_hi, WC_lo, DataID}; ECC[7:6] takes no part.
    logic [23:0] in_d;
    logic [5:0]  in_syn;
    logic        in_fire;
    logic        hdr_ready;

    assign in_d     = {bus.packet_header_i[15:8], bus.packet_header_i[23:16],
                       bus.packet_header_i[31:24]};
    assign in_syn   = ecc_parity(in_d) ^ bus.packet_header_i[5:0];
    assign in_fire  = bus.hdr_valid_i && hdr_ready;
    assign bus.hdr_ready_o = hdr_ready;

    // Candidate: the header about to be written into (or dropped before) the
    // output register this cycle.
    logic [23:0] cand_d;
    logic [5:0]  cand_syn;
    logic        cand_fire;
    logic        cand_drop;

    // Output register state.
    logic        out_valid;
    logic        out_adv;
    logic [15:0] out_len;
    logic [1:0]  out_vc;
    logic [5:0]  out_dt;
    logic [5:0]  out_syn;
    logic        out_no_err;
    logic        out_corr;
    logic        out_err;

    assign out_adv = !out_valid || bus.out_ready_i;

    if (PIPE_STAGES == 1) begin : g_pipe1
        // Single stage: decode straight from the input into the output register.
        assign cand_d    = in_d;
        assign cand_syn  = in_syn;
        assign hdr_ready = out_adv;
        assign cand_fire = in_fire;
    end else begin : g_pipe2
        logic        s1_valid;
        logic [23:0] s1_d;
        logic [5:0]  s1_syn;

        // Syndrome stage: load on input transfer, empty when its header leaves.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s1_valid <= 1'b0;
                s1_d     <= '0;
                s1_syn   <= '0;
            end else if (in_fire) begin
                s1_valid <= 1'b1;
                s1_d     <= in_d;
                s1_syn   <= in_syn;
            end else if (cand_fire) begin
                s1_valid <= 1'b0;
            end
        end

        assign cand_d    = s1_d;
        assign cand_syn  = s1_syn;
        // A header that will be dropped never needs the output slot, so it
        // leaves even while the output register is stalled.
        assign cand_fire = s1_valid && (cand_drop || out_adv);
        assign hdr_ready = !s1_valid || cand_fire;
    end

    // Correction and classification of the candidate header.
    logic [23:0] flip;
    logic [23:0] fixed_d;
    logic        dec_no_err;
    logic        dec_corr;
    logic        dec_unc;

    // Classify the syndrome, correct the data and decide whether to drop.
    always_comb begin
        flip       = column_flip(cand_syn);
        fixed_d    = cand_d ^ flip;
        dec_no_err = (cand_syn == 6'h00);
        dec_corr   = (|flip) || $onehot(cand_syn);
        dec_unc    = !dec_no_err && !dec_corr;
        // Uncorrectable headers have flip == 0, so this filters on the raw VC.
        cand_drop  = (dec_unc && DROP_UNCORR) || !vc_mask_i[fixed_d[7:6]];
    end

    // Output register: load a kept header, otherwise release on out_ready_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            out_len    <= '0;
            out_vc     <= '0;
            out_dt     <= '0;
            out_syn    <= '0;
            out_no_err <= 1'b0;
            out_corr   <= 1'b0;
            out_err    <= 1'b0;
        end else if (cand_fire && !cand_drop) begin
            out_valid  <= 1'b1;
            out_len    <= {fixed_d[23:16], fixed_d[15:8]};
            out_vc     <= fixed_d[7:6];
            out_dt     <= fixed_d[5:0];
            out_syn    <= cand_syn;
            out_no_err <= dec_no_err;
            out_corr   <= dec_corr;
            out_err    <= dec_unc;
        end else if (bus.out_ready_i) begin
            out_valid  <= 1'b0;
        end
    end

    assign bus.out_valid_o       = out_valid;
    assign bus.packet_length_o   = out_len;
    assign bus.vc_id_o           = out_vc;
    assign bus.data_type_o       = out_dt;
    assign bus.syndrome_o        = out_syn;
    assign bus.no_error_o        = out_no_err;
    assign bus.corrected_error_o = out_corr;
    assign bus.error_o           = out_err;

    // Statistics: one update per header as it leaves the candidate slot; clear wins.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            cnt_corrected_o   <= '0;
            cnt_uncorrected_o <= '0;
            cnt_dropped_o     <= '0;
        end else if (cand_fire) begin
            if (dec_corr) cnt_corrected_o   <= sat_inc(cnt_corrected_o);
            if (dec_unc)  cnt_uncorrected_o <= sat_inc(cnt_uncorrected_o);
            if (cand_drop) cnt_dropped_o    <= sat_inc(cnt_dropped_o);
        end
    end

endmodule

// File: doc/mipi_csi_rx_header_ecc_pipe.md
Name: mipi_csi_rx_header_ecc_pipe

Overview:
Pipelined, parametrised successor to the combinational CSI-2 packet-header ECC decoder. Accepts 32-bit packet headers on a valid/ready stream. Checks and corrects each header with the CSI-2 6-bit Hamming SECDED code, optionally drops uncorrectable headers, filters by virtual channel, and keeps saturating error-statistics counters. Sits between the lane merger/packet-boundary detector and the packet decoder FSM in the CSI RX path.

Parameters:
PIPE_STAGES, 2, pipeline depth: 1 = syndrome and correction in one registered stage; 2 = registered syndrome, then registered correction. Other values are illegal and rejected by an elaboration assertion.
DROP_UNCORR, 1, 1 = uncorrectable headers never appear on the output; 0 = forwarded with error_o=1.
CNT_W, 16, width of each statistics counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
hdr_valid_i  in  1  input header valid
hdr_ready_o  out  1  input ready
packet_header_i  in  32  {DataID[31:24], WC_lo[23:16], WC_hi[15:8], ECC[7:0]}
vc_mask_i  in  4  bit n=1 passes VC n; quasi-static
out_valid_o  out  1  output valid
out_ready_i  in  1  output ready
packet_length_o  out  16  corrected {WC_hi, WC_lo}
vc_id_o  out  2  corrected DataID[7:6]
data_type_o  out  6  corrected DataID[5:0]
syndrome_o  out  6  raw syndrome of this header
no_error_o  out  1  syndrome zero
corrected_error_o  out  1  single-bit error corrected
error_o  out  1  uncorrectable error
cnt_clr_i  in  1  synchronous clear of all counters
cnt_corrected_o  out  CNT_W  corrected-header count
cnt_uncorrected_o  out  CNT_W  uncorrectable-header count
cnt_dropped_o  out  CNT_W  headers dropped (uncorrectable and/or VC-filtered)

Behaviour:
- Reset (synchronous, active-high): all stage valids=0, out_valid_o=0, all data/flag outputs=0, counters=0. hdr_ready_o=1 from the first cycle after reset. A reset asserted mid-operation discards all in-flight headers; no partial output.
- Data vector: D[7:0]=hdr[31:24], D[15:8]=hdr[23:16], D[23:16]=hdr[15:8]. P0..P5 follow the MIPI CSI-2 header ECC equations. Syndrome = computed P XOR ECC[5:0]. ECC[7:6] is ignored.
- Decode:
  - Syndrome 0: no_error.
  - Syndrome equals a data column: flip that D bit, corrected.
  - Syndrome has exactly one bit set: parity-bit error, data unchanged, corrected.
  - Any other syndrome: error; data passed uncorrected.
  - Exactly one of no_error_o, corrected_error_o, error_o is 1 whenever out_valid_o=1.
- Handshake: each stage holds while valid && !advance. A stage advances when its successor is empty or advancing. The output stage advances on out_ready_i.
  - hdr_ready_o = !s1_valid || s1_advance (combinational path from out_ready_i is allowed).
  - Transfers occur on valid&&ready. Output data is stable while out_valid_o && !out_ready_i.
- Latency: PIPE_STAGES cycles from input transfer to out_valid_o with out_ready_i held high. Throughput is one header per cycle.
- Drop: a header is dropped if (error && DROP_UNCORR) or vc_mask_i[corrected VC]==0. Filtering uses the corrected VC; an uncorrectable header with DROP_UNCORR=0 is filtered on its raw VC. A dropped header leaves no bubble-stall: the output stage does not become valid for it, and it still frees its slot.
- Counters: updated once per header, in the cycle it is written into the output stage (or would be, if dropped).
  - Increment cnt_corrected_o / cnt_uncorrected_o per class; increment cnt_dropped_o per drop.
  - Counters saturate at 2^CNT_W-1, with no wrap.
  - cnt_clr_i wins over a simultaneous increment: result is 0 and that increment is lost.
- Simultaneous input accept and output drain in the same cycle: both occur, with no bubble.

Test Plan:
- Clean: 0x37F0013F, vc_mask=0xF -> after 2 cycles: packet_length_o=0x01F0, vc_id_o=0, data_type_o=0x37, syndrome_o=0, no_error_o=1, all counters 0.
- Single-bit: 0x27F0013F -> data_type_o=0x37 (corrected), syndrome_o=0x13, corrected_error_o=1, cnt_corrected_o=1. Then 0x37F0013E (ECC bit flip) -> syndrome_o=0x01, corrected, data unchanged, cnt_corrected_o=2.
- Double-bit: 0x07F0013F, DROP_UNCORR=1 -> no out_valid_o, cnt_uncorrected_o=1, cnt_dropped_o=1. With DROP_UNCORR=0 -> output with syndrome_o=0x06, error_o=1, data_type_o=0x07.
- Back-pressure: stream 5 clean headers, hold out_ready_i=0 for 4 cycles -> hdr_ready_o drops after PIPE_STAGES headers accepted. On release, all 5 are output in order, unchanged, with no loss or duplication.
- VC filter and counters: vc_mask_i=0xE with a VC0 header -> dropped, cnt_dropped_o increments. With CNT_W=4, 17 correctable headers -> cnt_corrected_o=15. cnt_clr_i in the same cycle as an increment -> 0.
- Reset mid-stream: assert rst_i with 2 headers in flight -> next cycle out_valid_o=0, counters=0. The first post-reset header emerges normally after PIPE_STAGES cycles.
